// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing with wait states.
// Exceptions (overflow, invalid opcode, divide-by-zero) are built only when MC_CTRL_EXC_EN is defined.
module mc_ctrl_fsm #(
    parameter int unsigned MEM_WAIT = 1,
    parameter int unsigned STATE_W  = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               overflow,
    input  logic               zero,
    input  logic               div_zero,
    input  logic               md_done,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               ir_write,
    output logic               reg_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               load_ab,
    output logic               alu_out_we,
    output logic               mdr_we,
    output logic               epc_write,
    output logic               hilo_we,
    output logic               md_start,
    output logic               md_sel,
    output logic [1:0]         iord,
    output logic [1:0]         reg_dst,
    output logic [2:0]         mem_to_reg,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_op,
    output logic [1:0]         pc_src,
    output logic [1:0]         exc_cause,
    output logic [STATE_W-1:0] state_dbg
);

`ifdef MC_CTRL_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    localparam bit         HAS_WAIT  = (MEM_WAIT != 0);
    localparam logic [2:0] WAIT_LAST = (MEM_WAIT == 0) ? 3'd0 : 3'(MEM_WAIT - 1);

    typedef enum logic [STATE_W-1:0] {
        S_RST, S_FETCH, S_WAIT_F, S_IR_LD, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_R, S_WB_I,
        S_MEM_ADDR, S_MEM_RD, S_WAIT_M, S_MDR_LD, S_LD_WB, S_MEM_WR, S_BRANCH, S_JUMP,
        S_MD_START, S_MD_WAIT, S_MD_WB, S_EXC_EPC, S_EXC_WAIT, S_EXC_MDR, S_EXC_LD
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [1:0] cause_q, cause_d;

    logic r_type, op_add, op_sub, op_and, op_mult, op_div;
    logic op_addi, op_addiu, op_beq, op_lw, op_sw, op_j, div_trap;
    logic unused_zero;

    // zero feeds the datapath's branch qualification alongside pc_write_cond
    assign unused_zero = zero;

    assign r_type   = (opcode == 6'h00);
    assign op_add   = r_type && (funct == 6'h20);
    assign op_sub   = r_type && (funct == 6'h22);
    assign op_and   = r_type && (funct == 6'h24);
    assign op_mult  = r_type && (funct == 6'h18);
    assign op_div   = r_type && (funct == 6'h1A);
    assign op_addi  = (opcode == 6'h08);
    assign op_addiu = (opcode == 6'h09);
    assign op_beq   = (opcode == 6'h04);
    assign op_lw    = (opcode == 6'h23);
    assign op_sw    = (opcode == 6'h2B);
    assign op_j     = (opcode == 6'h02);
    assign div_trap = EXC_EN && op_div && div_zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RST;
            cnt_q   <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        cause_d = cause_q;
        case (state_q)
            S_RST:      state_d = S_FETCH;
            S_FETCH:    state_d = HAS_WAIT ? S_WAIT_F : S_IR_LD;
            S_WAIT_F:   if (cnt_q == WAIT_LAST) state_d = S_IR_LD; else cnt_d = cnt_q + 3'd1;
            S_IR_LD:    state_d = S_DECODE;
            S_DECODE: begin
                if (op_add || op_sub || op_and)  state_d = S_EXEC_R;
                else if (op_mult || op_div)      state_d = S_MD_START;
                else if (op_addi || op_addiu)    state_d = S_EXEC_I;
                else if (op_lw || op_sw)         state_d = S_MEM_ADDR;
                else if (op_beq)                 state_d = S_BRANCH;
                else if (op_j)                   state_d = S_JUMP;
                else if (EXC_EN) begin
                    state_d = S_EXC_EPC;
                    cause_d = 2'b00;
                end else                         state_d = S_FETCH;
            end
            S_EXEC_R: begin
                if (EXC_EN && overflow && (op_add || op_sub)) begin
                    state_d = S_EXC_EPC;
                    cause_d = 2'b01;
                end else state_d = S_WB_R;
            end
            S_EXEC_I: begin
                if (EXC_EN && overflow && op_addi) begin
                    state_d = S_EXC_EPC;
                    cause_d = 2'b01;
                end else state_d = S_WB_I;
            end
            S_WB_R, S_WB_I: state_d = S_FETCH;
            S_MEM_ADDR: state_d = op_lw ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = HAS_WAIT ? S_WAIT_M : S_MDR_LD;
            S_WAIT_M:   if (cnt_q == WAIT_LAST) state_d = S_MDR_LD; else cnt_d = cnt_q + 3'd1;
            S_MDR_LD:   state_d = S_LD_WB;
            S_LD_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_MD_WB, S_EXC_LD: state_d = S_FETCH;
            S_MD_START: begin
                if (div_trap) begin
                    state_d = S_EXC_EPC;
                    cause_d = 2'b10;
                end else state_d = S_MD_WAIT;
            end
            S_MD_WAIT:  if (md_done) state_d = S_MD_WB;
            // Vector byte is captured into MDR after the wait, so EXC_LD can use pc_src=11
            S_EXC_EPC:  state_d = HAS_WAIT ? S_EXC_WAIT : S_EXC_MDR;
            S_EXC_WAIT: if (cnt_q == WAIT_LAST) state_d = S_EXC_MDR; else cnt_d = cnt_q + 3'd1;
            S_EXC_MDR:  state_d = S_EXC_LD;
            default:    state_d = S_RST;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        load_ab       = 1'b0;
        alu_out_we    = 1'b0;
        mdr_we        = 1'b0;
        epc_write     = 1'b0;
        hilo_we       = 1'b0;
        md_start      = 1'b0;
        md_sel        = 1'b0;
        iord          = 2'b00;
        reg_dst       = 2'b00;
        mem_to_reg    = 3'b000;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 3'b000;
        pc_src        = 2'b00;
        case (state_q)
            S_RST:      begin reg_write = 1'b1; reg_dst = 2'b10; mem_to_reg = 3'b111; end
            S_FETCH:    mem_read = 1'b1;
            S_IR_LD:    begin ir_write = 1'b1; pc_write = 1'b1; alu_src_b = 2'b01; alu_op = 3'b001; end
            S_DECODE:   begin load_ab = 1'b1; alu_out_we = 1'b1; alu_src_b = 2'b11; alu_op = 3'b001; end
            S_EXEC_R:   begin alu_src_a = 2'b01; alu_out_we = 1'b1; end
            S_EXEC_I:   begin alu_src_a = 2'b01; alu_src_b = 2'b10; alu_out_we = 1'b1; end
            S_WB_R:     begin reg_write = 1'b1; reg_dst = 2'b01; end
            S_WB_I:     reg_write = 1'b1;
            S_MEM_ADDR: begin
                alu_src_a = 2'b01; alu_src_b = 2'b10; alu_op = 3'b001; alu_out_we = 1'b1;
            end
            S_MEM_RD:   begin mem_read = 1'b1; iord = 2'b01; end
            S_MDR_LD:   mdr_we = 1'b1;
            S_LD_WB:    begin reg_write = 1'b1; mem_to_reg = 3'b001; end
            S_MEM_WR:   begin mem_write = 1'b1; iord = 2'b01; end
            S_BRANCH:   begin alu_op = 3'b010; pc_write_cond = 1'b1; pc_src = 2'b01; end
            S_JUMP:     begin pc_write = 1'b1; pc_src = 2'b10; end
            // A trapping div must never launch the unit, so the strobe is qualified here
            S_MD_START: begin md_start = !div_trap; md_sel = op_div && !div_trap; end
            S_MD_WB:    hilo_we = 1'b1;
            S_EXC_EPC:  begin
                epc_write = EXC_EN; alu_src_b = 2'b01; alu_op = 3'b010;
                mem_read = 1'b1; iord = 2'b10;
            end
            S_EXC_MDR:  mdr_we = 1'b1;
            S_EXC_LD:   begin pc_write = 1'b1; pc_src = 2'b11; end
            default:    ;
        endcase
    end

    assign exc_cause = EXC_EN ? cause_q : 2'b00;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: every cycle with any strobe/select active is an event
// compared (cycle stamp and full output bundle) against hand-derived expectations.
module tb_mc_ctrl_fsm;
    localparam int W = 2;

`ifdef MC_CTRL_EXC_EN
    localparam bit EXC = 1'b1;
`else
    localparam bit EXC = 1'b0;
`endif

    logic       clk = 1'b0, reset = 1'b1;
    logic [5:0] opcode = '0, funct = '0;
    logic       overflow = 1'b0, zero = 1'b0, div_zero = 1'b0, md_done = 1'b0;
    logic       pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write, load_ab;
    logic       alu_out_we, mdr_we, epc_write, hilo_we, md_start, md_sel;
    logic [1:0] iord, reg_dst, alu_src_a, alu_src_b, pc_src, exc_cause;
    logic [2:0] mem_to_reg, alu_op;
    logic [4:0] dbg_state_unused;

    mc_ctrl_fsm #(.MEM_WAIT(W), .STATE_W(5)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .overflow(overflow),
        .zero(zero), .div_zero(div_zero), .md_done(md_done), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .ir_write(ir_write), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .load_ab(load_ab), .alu_out_we(alu_out_we),
        .mdr_we(mdr_we), .epc_write(epc_write), .hilo_we(hilo_we), .md_start(md_start),
        .md_sel(md_sel), .iord(iord), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .exc_cause(exc_cause), .state_dbg(dbg_state_unused)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write, load_ab;
        logic alu_out_we, mdr_we, epc_write, hilo_we, md_start, md_sel;
        logic [1:0] iord, reg_dst;
        logic [2:0] mem_to_reg;
        logic [1:0] alu_src_a, alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src, exc_cause;
    } ov_t;

    typedef struct { int c; ov_t v; } ev_t;

    localparam int S_RST = 0, S_FETCH = 1, S_IRLD = 2, S_DEC = 3, S_EXR = 4, S_EXI = 5;
    localparam int S_WBR = 6, S_WBI = 7, S_MADDR = 8, S_MRD = 9, S_MDR = 10, S_LDWB = 11;
    localparam int S_MWR = 12, S_BR = 13, S_J = 14, S_MDS = 15, S_MDWB = 16, S_EPC = 17;
    localparam int S_XMDR = 18, S_XLD = 19;

    ev_t        q[$];
    int         checks = 0, failures = 0, t = 1;
    logic [1:0] cause = 2'b00;
    ov_t        act;

    assign act = {pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write, load_ab,
                  alu_out_we, mdr_we, epc_write, hilo_we, md_start, md_sel, iord, reg_dst,
                  mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, exc_cause};

    function automatic ov_t vec(input int s, input logic sel);
        ov_t v = '0;
        v.exc_cause = cause;
        case (s)
            S_RST:   begin v.reg_write = 1; v.reg_dst = 2'b10; v.mem_to_reg = 3'b111; end
            S_FETCH: v.mem_read = 1;
            S_IRLD:  begin v.ir_write = 1; v.pc_write = 1; v.alu_src_b = 2'b01; v.alu_op = 3'b001; end
            S_DEC:   begin v.load_ab = 1; v.alu_out_we = 1; v.alu_src_b = 2'b11; v.alu_op = 3'b001; end
            S_EXR:   begin v.alu_src_a = 2'b01; v.alu_out_we = 1; end
            S_EXI:   begin v.alu_src_a = 2'b01; v.alu_src_b = 2'b10; v.alu_out_we = 1; end
            S_WBR:   begin v.reg_write = 1; v.reg_dst = 2'b01; end
            S_WBI:   v.reg_write = 1;
            S_MADDR: begin v.alu_src_a = 2'b01; v.alu_src_b = 2'b10; v.alu_op = 3'b001; v.alu_out_we = 1; end
            S_MRD:   begin v.mem_read = 1; v.iord = 2'b01; end
            S_MDR:   v.mdr_we = 1;
            S_LDWB:  begin v.reg_write = 1; v.mem_to_reg = 3'b001; end
            S_MWR:   begin v.mem_write = 1; v.iord = 2'b01; end
            S_BR:    begin v.alu_op = 3'b010; v.pc_write_cond = 1; v.pc_src = 2'b01; end
            S_J:     begin v.pc_write = 1; v.pc_src = 2'b10; end
            S_MDS:   begin v.md_start = 1; v.md_sel = sel; end
            S_MDWB:  v.hilo_we = 1;
            S_EPC:   begin
                v.epc_write = 1; v.alu_src_b = 2'b01; v.alu_op = 3'b010; v.mem_read = 1; v.iord = 2'b10;
            end
            S_XMDR:  v.mdr_we = 1;
            S_XLD:   begin v.pc_write = 1; v.pc_src = 2'b11; end
            default: ;
        endcase
        return v;
    endfunction

    task automatic push(input int s, input logic sel = 1'b0);
        ev_t e;
        e.c = t;
        e.v = vec(s, sel);
        q.push_back(e);
        t++;
    endtask

    // Moves the driver to 2 time units after the posedge that starts cycle c.
    task automatic at(input int c);
        if (c < cyc) begin
            failures++;
            $display("FAIL sched: at cycle %0d, required cycle %0d", cyc, c);
        end
        while (cyc < c) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] fn);
        at(t);
        opcode = op; funct = fn; overflow = 1'b0; div_zero = 1'b0; md_done = 1'b0;
        push(S_FETCH);
        t += W;
        push(S_IRLD);
        push(S_DEC);
    endtask

    task automatic exc_seq(input logic [1:0] c);
        cause = c;
        push(S_EPC);
        t += W;
        push(S_XMDR);
        push(S_XLD);
    endtask

    task automatic alu(input logic [5:0] op, input logic [5:0] fn, input bit isr,
                       input bit ovf, input bit trap);
        int ex;
        instr(op, fn);
        ex = t;
        push(isr ? S_EXR : S_EXI);
        if (trap && EXC) exc_seq(2'b01);
        else push(isr ? S_WBR : S_WBI);
        if (ovf) begin
            at(ex);
            overflow = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        ov_t m;
        ev_t e;
        m = act;
        m.exc_cause = 2'b00;
        if (cyc >= 1 && m != '0) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event: cyc=%0d got=%h required=none", cyc, act);
            end else begin
                e = q.pop_front();
                if (e.c != cyc || e.v != act) begin
                    failures++;
                    $display("FAIL event: cyc=%0d got=%h required cyc=%0d vec=%h", cyc, act, e.c, e.v);
                end
            end
        end
    end

    initial begin
        int m, e;
        // reset sampled high at posedges 1..3, FETCH from cycle 4
        push(S_RST); push(S_RST); push(S_RST);
        opcode = 6'h00; funct = 6'h20;
        at(3);
        reset = 1'b0;

        alu(6'h00, 6'h20, 1, 0, 0);   // add
        alu(6'h00, 6'h20, 1, 1, 1);   // add, overflow
        alu(6'h09, 6'h20, 0, 1, 0);   // addiu, overflow never traps
        alu(6'h00, 6'h24, 1, 1, 0);   // and, overflow never traps
        alu(6'h08, 6'h00, 0, 1, 1);   // addi, overflow
        alu(6'h00, 6'h22, 1, 1, 1);   // sub, overflow
        alu(6'h08, 6'h00, 0, 0, 0);   // addi

        instr(6'h23, 6'h00);          // lw: 7+2W cycles
        push(S_MADDR); push(S_MRD); t += W; push(S_MDR); push(S_LDWB);
        instr(6'h2B, 6'h00);          // sw
        push(S_MADDR); push(S_MWR);
        instr(6'h04, 6'h00);          // beq
        push(S_BR);
        instr(6'h02, 6'h00);          // j
        push(S_J);

        instr(6'h00, 6'h18);          // mult; early md_done ignored, real one after 32 cycles
        m = t;
        push(S_MDS, 1'b0);
        t = m + 33;
        push(S_MDWB);
        at(m);      md_done = 1'b1;
        at(m + 1);  md_done = 1'b0;
        at(m + 32); md_done = 1'b1;
        at(m + 33); md_done = 1'b0;

        instr(6'h3F, 6'h00);          // invalid opcode
        if (EXC) exc_seq(2'b00);
        instr(6'h00, 6'h3F);          // invalid funct
        if (EXC) exc_seq(2'b00);

        instr(6'h00, 6'h1A);          // div by zero
        div_zero = 1'b1;
        m = t;
        if (EXC) begin
            t++;
            exc_seq(2'b10);
        end else begin
            push(S_MDS, 1'b1);
            t = m + 4;
            push(S_MDWB);
            at(m + 3); md_done = 1'b1;
            at(m + 4); md_done = 1'b0;
        end

        instr(6'h00, 6'h1A);          // div
        m = t;
        push(S_MDS, 1'b1);
        t = m + 6;
        push(S_MDWB);
        at(m + 5); md_done = 1'b1;
        at(m + 6); md_done = 1'b0;

        instr(6'h00, 6'h18);          // mult abandoned by reset in MD_WAIT
        m = t;
        push(S_MDS, 1'b0);
        t = m + 3;
        cause = 2'b00;
        push(S_RST);
        at(m + 2); reset = 1'b1;
        at(m + 3); reset = 1'b0;

        alu(6'h00, 6'h24, 1, 0, 0);   // and after reset

        e = t;
        push(S_FETCH); push(S_RST); push(S_RST);
        at(e); reset = 1'b1;
        at(e + 2);
        #4;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL leftover_events: got %0d pending, required 0 (next cyc=%0d)", q.size(), q[0].c);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
